// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide unit:
// op codes, FSM state encoding and default width.
package muldiv_pkg;

    localparam int DEF_WIDTH = 32;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } state_t;

endpackage

// File: rtl/muldiv_datapath.sv
// Shift-add multiply / restoring divide accumulators with
// magnitude load and final sign correction.
module muldiv_datapath
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    logic [WIDTH:0]     acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic [WIDTH-1:0]   dvs;
    logic               sa;
    logic               sb;
    logic               div_q;

    logic               sgn;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     diff;
    logic               ge;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_f;

    assign sgn   = (op == OP_MULT) || (op == OP_DIV);
    assign mag_a = (sgn && a[WIDTH-1]) ? -a : a;
    assign mag_b = (sgn && b[WIDTH-1]) ? -b : b;

    assign mul_sum = acc_hi + (acc_lo[0] ? {1'b0, dvs} : '0);
    assign rem_sh  = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
    assign diff    = rem_sh - {1'b0, dvs};
    assign ge      = rem_sh >= {1'b0, dvs};

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_hi <= '0;
            acc_lo <= '0;
            dvs    <= '0;
            sa     <= 1'b0;
            sb     <= 1'b0;
            div_q  <= 1'b0;
        end else if (load) begin
            acc_hi <= '0;
            acc_lo <= mag_a;
            dvs    <= mag_b;
            sa     <= sgn && a[WIDTH-1];
            sb     <= sgn && b[WIDTH-1];
            div_q  <= (op == OP_DIV) || (op == OP_DIVU);
        end else if (step) begin
            if (div_q) begin
                acc_hi <= ge ? diff : rem_sh;
                acc_lo <= {acc_lo[WIDTH-2:0], ge};
            end else begin
                acc_hi <= {1'b0, mul_sum[WIDTH:1]};
                acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
            end
        end
    end

    // Truncating division: remainder follows the dividend's sign
    always_comb begin
        prod   = {acc_hi[WIDTH-1:0], acc_lo};
        prod_f = (sa ^ sb) ? -prod : prod;
        res_hi = prod_f[2*WIDTH-1:WIDTH];
        res_lo = prod_f[WIDTH-1:0];
        if (div_q) begin
            res_hi = sa ? -acc_hi[WIDTH-1:0] : acc_hi[WIDTH-1:0];
            res_lo = (sa ^ sb) ? -acc_lo : acc_lo;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/DIV engine owning HI/LO, with start/busy
// handshake and HI/LO hazard stall request.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             rd_hilo,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_q;
    state_t           state_d;
    logic [CW-1:0]    cnt_q;
    logic             nowr_q;
    logic             done_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    logic             load;
    logic             step;
    logic             is_mul;
    logic             is_div;
    logic             b_zero;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;

    assign is_mul = (op == OP_MULT) || (op == OP_MULTU);
    assign is_div = (op == OP_DIV) || (op == OP_DIVU);
    assign b_zero = (b == '0);

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && is_mul) begin
                    state_d = MUL;
                    load    = 1'b1;
                end else if (start && is_div) begin
                    state_d = b_zero ? FIX : DIV;
                    load    = 1'b1;
                end
            end
            MUL, DIV: begin
                step = 1'b1;
                if (cnt_q == LAST) state_d = FIX;
            end
            FIX: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            nowr_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == FIX);
            if (step) cnt_q <= cnt_q + 1'b1;
            if (state_q == IDLE) begin
                cnt_q  <= '0;
                nowr_q <= start && is_div && b_zero;
                if (start && op == OP_MTHI) hi_q <= a;
                if (start && op == OP_MTLO) lo_q <= a;
            end
            if (state_q == FIX && !nowr_q) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
            end
        end
    end

    assign busy  = (state_q != IDLE);
    assign done  = done_q;
    assign stall = busy && (start || rd_hilo);
    assign hi    = hi_q;
    assign lo    = lo_q;

    muldiv_datapath #(
        .WIDTH(WIDTH)
    ) u_dp (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .step  (step),
        .op    (op),
        .a     (a),
        .b     (b),
        .res_hi(res_hi),
        .res_lo(res_lo)
    );

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
// Inputs change on negedge; outputs sampled on negedge.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        rd_hilo = 1'b0;
    logic        busy;
    logic        done;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int npass = 0;
    int ntot  = 0;

    muldiv_unit dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .rd_hilo(rd_hilo),
        .busy   (busy),
        .done   (done),
        .stall  (stall),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] x,
                         input logic [31:0] y);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_idle(output int bc);
        bc = 0;
        while (busy === 1'b1 && bc < 100) begin
            bc++;
            @(negedge clk);
        end
    endtask

    task automatic run(input string tag, input logic [2:0] o,
                       input logic [31:0] x, input logic [31:0] y,
                       input int ebc, input logic [31:0] ehi,
                       input logic [31:0] elo);
        int bc;
        issue(o, x, y);
        wait_idle(bc);
        chk({tag, "_busycyc"}, 64'(bc), 64'(ebc));
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_hi"}, 64'(hi), 64'(ehi));
        chk({tag, "_lo"}, 64'(lo), 64'(elo));
        @(negedge clk);
        chk({tag, "_done_off"}, 64'(done), 64'd0);
    endtask

    initial begin
        int bc;
        bit saw;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);

        run("multu_max", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF,
            33, 32'hFFFFFFFE, 32'h00000001);
        run("mult_neg", 3'd0, 32'hFFFFFFFD, 32'd5,
            33, 32'hFFFFFFFF, 32'hFFFFFFF1);
        run("div_neg", 3'd2, 32'hFFFFFFF9, 32'd2,
            33, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run("divu", 3'd3, 32'd100, 32'd7,
            33, 32'h00000002, 32'h0000000E);
        run("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF,
            33, 32'h00000000, 32'h80000000);

        issue(3'd4, 32'h12345678, 32'd0);
        chk("mthi_hi", 64'(hi), 64'h12345678);
        chk("mthi_busy", 64'(busy), 64'd0);
        chk("mthi_done", 64'(done), 64'd0);
        issue(3'd5, 32'h9ABCDEF0, 32'd0);
        chk("mtlo_lo", 64'(lo), 64'h9ABCDEF0);
        chk("mtlo_hi", 64'(hi), 64'h12345678);
        chk("mtlo_done", 64'(done), 64'd0);

        run("divz", 3'd3, 32'd55, 32'd0,
            1, 32'h12345678, 32'h9ABCDEF0);

        issue(3'd6, 32'd1, 32'd1);
        chk("op6_busy", 64'(busy), 64'd0);
        chk("op6_hi", 64'(hi), 64'h12345678);
        chk("op6_lo", 64'(lo), 64'h9ABCDEF0);

        issue(3'd1, 32'd3, 32'd5);
        chk("stall_idle_rd", 64'(stall), 64'd0);
        repeat (3) @(negedge clk);
        rd_hilo = 1'b1;
        #1 chk("stall_rd", 64'(stall), 64'd1);
        start = 1'b1;
        op    = 3'd1;
        a     = 32'd7;
        b     = 32'd7;
        #1 chk("stall_start", 64'(stall), 64'd1);
        @(negedge clk);
        start   = 1'b0;
        rd_hilo = 1'b0;
        #1 chk("stall_off", 64'(stall), 64'd0);
        chk("stall_busy", 64'(busy), 64'd1);
        wait_idle(bc);
        chk("stall_done", 64'(done), 64'd1);
        chk("stall_hi", 64'(hi), 64'd0);
        chk("stall_lo", 64'(lo), 64'd15);
        @(negedge clk);
        chk("stall_no2nd", 64'(busy), 64'd0);

        issue(3'd1, 32'hFFFFFFFF, 32'd2);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_hi", 64'(hi), 64'd0);
        chk("mid_rst_lo", 64'(lo), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        saw = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) saw = 1'b1;
            @(negedge clk);
        end
        chk("mid_rst_nodone", 64'(saw), 64'd0);
        chk("mid_rst_lo_end", 64'(lo), 64'd0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
